requant_clamp_pipe: RTL

- Multi-lane, pipelined requantisation stage that follows the accumulators in the neural-network datapath.
- Per beat and per lane:
  - arithmetic right shift by a runtime amount, with round-half-up;
  - optional ReLU;
  - signed saturation to WIDTH_OUT.
- Uses valid/ready flow control on both sides.
- Keeps a saturating count of clamped lanes and a sticky overflow flag for debug and calibration.

---
 rtl/requant_clamp_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/requant_clamp_pipe.sv
// Multi-lane requantiser: per-lane rounding arithmetic right shift, optional ReLU and
// signed saturation, two-stage valid/ready pipeline with a saturating clamp counter.
module requant_clamp_pipe #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 8,
    parameter int NCH       = 4,
    parameter int SHIFT_W   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH*WIDTH_IN-1:0]  in_data,
    input  logic [SHIFT_W-1:0]       shift_amt,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*WIDTH_OUT-1:0] out_data,
    output logic [CNT_W-1:0]         sat_count,
    output logic                     sat_sticky,
    input  logic                     cnt_clr
);

    localparam int RW    = WIDTH_IN + 1;
    localparam int K_W   = $clog2(NCH + 1);
    localparam int SUM_W = ((CNT_W > K_W) ? CNT_W : K_W) + 1;

    localparam logic signed [RW-1:0] T_MAX = {{(RW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [RW-1:0] T_MIN = {{(RW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

    logic                     s1_valid_q;
    logic                     s1_relu_q;
    logic [NCH*RW-1:0]        s1_r_q;
    logic [NCH*RW-1:0]        s1_r_d;
    logic                     out_valid_q;
    logic [NCH*WIDTH_OUT-1:0] out_data_q;
    logic [NCH*WIDTH_OUT-1:0] out_data_d;
    logic [NCH-1:0]           lane_sat;
    logic [K_W-1:0]           sat_k;
    logic [SUM_W-1:0]         sat_sum;
    logic [CNT_W-1:0]         sat_count_q;
    logic [CNT_W-1:0]         sat_count_d;
    logic                     sat_sticky_q;
    logic                     sat_sticky_d;
    logic                     en1;
    logic                     en2;
    logic [SHIFT_W-1:0]       sh;

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign sat_count  = sat_count_q;
    assign sat_sticky = sat_sticky_q;

    always_comb begin
        if (32'(shift_amt) >= 32'(WIDTH_IN)) begin
            sh = SHIFT_W'(WIDTH_IN - 1);
        end else begin
            sh = shift_amt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            logic signed [RW-1:0]        x_ext;
            logic signed [RW-1:0]        rnd;
            logic signed [RW-1:0]        sum;
            logic signed [RW-1:0]        rv;
            logic        [WIDTH_OUT-1:0] y;
            logic                        sat;

            // One guard bit above WIDTH_IN keeps x + half-LSB from wrapping.
            assign x_ext = RW'($signed(in_data[gi*WIDTH_IN +: WIDTH_IN]));
            assign rnd   = (sh == '0) ? '0 : (RW'(1) << (sh - SHIFT_W'(1)));
            assign sum   = x_ext + rnd;
            assign s1_r_d[gi*RW +: RW] = sum >>> sh;

            assign rv = s1_r_q[gi*RW +: RW];

            always_comb begin
                y   = rv[WIDTH_OUT-1:0];
                sat = 1'b0;
                if (s1_relu_q && rv < 0) begin
                    y = '0;
                end else if (rv > T_MAX) begin
                    y   = T_MAX[WIDTH_OUT-1:0];
                    sat = 1'b1;
                end else if (rv < T_MIN) begin
                    y   = T_MIN[WIDTH_OUT-1:0];
                    sat = 1'b1;
                end
            end

            assign out_data_d[gi*WIDTH_OUT +: WIDTH_OUT] = y;
            assign lane_sat[gi] = sat;
        end
    endgenerate

    always_comb begin
        sat_k = '0;
        for (int i = 0; i < NCH; i++) begin
            sat_k = sat_k + K_W'(lane_sat[i]);
        end
    end

    assign sat_sum = SUM_W'(sat_count_q) + SUM_W'(sat_k);

    // Only a beat moving into S2 is counted, so a held output beat is never re-counted.
    always_comb begin
        sat_count_d  = sat_count_q;
        sat_sticky_d = sat_sticky_q;
        if (cnt_clr) begin
            sat_count_d  = '0;
            sat_sticky_d = 1'b0;
        end else if (en2 && s1_valid_q) begin
            if (sat_sum > SUM_W'({CNT_W{1'b1}})) begin
                sat_count_d = '1;
            end else begin
                sat_count_d = sat_sum[CNT_W-1:0];
            end
            if (sat_k != '0) begin
                sat_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_relu_q    <= 1'b0;
            s1_r_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sat_count_q  <= '0;
            sat_sticky_q <= 1'b0;
        end else begin
            if (en1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_r_q    <= s1_r_d;
                    s1_relu_q <= relu_en;
                end
            end
            if (en2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                end
            end
            sat_count_q  <= sat_count_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

endmodule
